uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter between `NumReq` byte-stream requesters, such as the CPU MMIO store path and the debug/monitor path. It grants the transmitter to one requester at a time, round-robin, and holds the grant for a whole message until a byte flagged `Last` is accepted. A grant is released early if the owner stalls longer than `IdleTimeout` cycles. It drives the transmitter's `DataIn`/`DataInValid`/`DataInReady` handshake. It also keeps `TxData` stable for the full serial frame, because the transmitter samples `DataIn` throughout transmission.

## Interface
- `NumReq`, 2, number of requesters, 2..4.
- `IdleTimeout`, 1024, stall cycles before a locked grant is released; 0 disables the timeout.
- `GrantIdWidth`, derived, equals max(1, ceil(log2(NumReq))).
- `CountWidth`, derived, equals `log2(IdleTimeout+1)` via `util.vh`.

Ports (name, direction, width, meaning):
- `Clock`  in  1  sole clock.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `ReqData`  in  8*NumReq  byte for requester i, at bits [8i+7:8i].
- `ReqValid`  in  NumReq  byte valid, per requester.
- `ReqLast`  in  NumReq  byte ends the message, per requester.
- `ReqReady`  out  NumReq  byte accepted this cycle when valid&ready.
- `TxData`  out  8  connects to transmitter `DataIn`.
- `TxValid`  out  1  connects to transmitter `DataInValid`.
- `TxReady`  in  1  connects to transmitter `DataInReady`; high when the transmitter is idle.
- `GrantValid`  out  1  a requester currently holds the lock.
- `GrantId`  out  GrantIdWidth  index of the owner; meaningful only when `GrantValid` is high.

## Operation
- FSM states: IDLE and LOCKED.
- IDLE:
  - If any `ReqValid` bit is set, pick the first set bit searching from `RrPtr` upward with wrap.
  - Register that index as the owner and go to LOCKED. No byte is accepted in the arbitration cycle.
- LOCKED:
  - `ReqReady[owner] = !TxValid && TxReady`. All other `ReqReady` bits are 0.
  - On accept: `TxData` ← byte, `TxValid` ← 1, and the idle counter clears.
  - If the accepted byte has `ReqLast`: go to IDLE and set `RrPtr` ← owner+1 mod NumReq.
- Output register:
  - `TxValid` drops the cycle after the `TxValid && TxReady` handshake.
  - `TxData` is held unchanged after the handshake until the next accept.
  - A new byte loads only while `TxValid==0 && TxReady==1`, so `TxData` never changes during a frame.
- Idle timeout, when `IdleTimeout` != 0:
  - The counter increments in LOCKED on every cycle with no accept, and saturates.
  - When the counter reaches `IdleTimeout`, go to IDLE with `RrPtr` ← owner+1.
  - A pending `TxValid` byte is still delivered.
- `ReqData`/`ReqLast` of non-owners are ignored. A requester that drops `ReqValid` mid-message keeps the lock until timeout.
- Simultaneous events:
  - An accept and a timeout hit on the same cycle: the accept wins and the counter clears.
  - Last-accept and a new request on the same cycle: the new request is arbitrated from IDLE on the next cycle.

## Timing
- Reset values, applied asynchronously:
  - State IDLE, `RrPtr`=0, counter 0.
  - `TxValid`=0, `TxData`=8'h00.
  - `ReqReady`=0, `GrantValid`=0, `GrantId`=0.
- Reset mid-message: the pending byte is discarded and the lock is dropped.
- Latency from first `ReqValid` (cycle 0) with the transmitter idle:
  - Cycle 1: LOCKED, `GrantValid`=1, `ReqReady[owner]`=1.
  - Cycle 2: `TxValid`=1.
- The transmitter starts on the edge ending cycle 2; `TxValid`=0 from cycle 3.
- Next accept happens on the first cycle with `TxReady`=1 and `TxValid`=0. That is one byte per serial frame, plus one cycle.
- `GrantValid`/`GrantId` are registered. `ReqReady` is combinational from state, `TxValid` and `TxReady` only, with no dependency on `ReqValid`.

## Structure
- Constants shared with the UART wrapper and MMIO decode go in a shared header alongside `util.vh`: the FSM state encodings (IDLE=1'b0, LOCKED=1'b1) and the default `NumReq`/`IdleTimeout`.
- One sub-module, `rr_pick`: a combinational round-robin priority picker. Inputs are request vector and pointer; outputs are `Found` and `Index`.
- Everything else (FSM, output register, timeout counter) is in `uart_tx_arbiter`.

## Test plan
- **Single message:** req0 sends 8'h48, 8'h69 (Last) with the transmitter idle.
  - `GrantId`=0 at cycle 1 and `TxValid` at cycle 2.
  - `TxData` stays 8'h48 until the transmitter finishes.
  - Serial line shows 0x48 then 0x69, then IDLE.
- **Contention:** req0 and req1 both valid at cycle 0 with `RrPtr`=0.
  - req0's 3-byte message is sent completely before any req1 byte.
  - Next arbitration picks req1; a following simultaneous request picks req0.
- **Data stability:** while `TxReady`=0, toggle `ReqData[0]` every cycle.
  - `TxData` and `ReqReady[0]` stay constant, at 0.
- **Timeout:** `IdleTimeout`=16; req1 sends one non-Last byte, then drops valid, while req0 is waiting.
  - After 16 stall cycles, `GrantValid` falls; req0 is granted next.
- **Reset mid-message:** assert `Reset_n`=0 asynchronously while `TxValid`=1.
  - All outputs go to their reset values immediately.
  - After release, arbitration restarts from req0.
- **Timeout disabled:** `IdleTimeout`=0, owner stalls for 10000 cycles.
  - The lock is held throughout; other requesters never see `ReqReady`.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART transmit arbiter: FSM encoding, default sizing and width helpers.
package uart_tx_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ      = 2;
    localparam int DEF_IDLE_TIMEOUT = 1024;

    function automatic int grant_id_width(input int num_req);
        return (num_req <= 2) ? 1 : $clog2(num_req);
    endfunction

    // Bits needed to hold the value `timeout`; never narrower than one bit.
    function automatic int count_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above Ptr, wrapping to 0.
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NumReq  = DEF_NUM_REQ,
    parameter int IdWidth = grant_id_width(NumReq)
) (
    input  logic [NumReq-1:0]  Req,
    input  logic [IdWidth-1:0] Ptr,
    output logic               Found,
    output logic [IdWidth-1:0] Index
);

    always_comb begin
        Found = 1'b0;
        Index = '0;
        for (int k = 0; k < NumReq; k++) begin
            int idx;
            idx = int'(Ptr) + k;
            if (idx >= NumReq) idx = idx - NumReq;
            if (!Found && Req[idx]) begin
                Found = 1'b1;
                Index = IdWidth'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter in front of a single UART transmitter.
//   state     | meaning
//   ST_IDLE   | no owner; pick next requester from the round-robin pointer
//   ST_LOCKED | owner streams bytes until a Last byte is accepted or it stalls out
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NumReq       = DEF_NUM_REQ,
    parameter int IdleTimeout  = DEF_IDLE_TIMEOUT,
    parameter int GrantIdWidth = grant_id_width(NumReq),
    parameter int CountWidth   = count_width(IdleTimeout)
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    input  logic [8*NumReq-1:0]     ReqData,
    input  logic [NumReq-1:0]       ReqValid,
    input  logic [NumReq-1:0]       ReqLast,
    output logic [NumReq-1:0]       ReqReady,
    output logic [7:0]              TxData,
    output logic                    TxValid,
    input  logic                    TxReady,
    output logic                    GrantValid,
    output logic [GrantIdWidth-1:0] GrantId
);

    arb_state_t              r_state, w_state_next;
    logic [GrantIdWidth-1:0] r_rr_ptr, w_ptr_next;
    logic [GrantIdWidth-1:0] r_owner, w_owner_next, w_owner_inc;
    logic [CountWidth-1:0]   r_idle_cnt, w_idle_cnt_next;
    logic                    r_tx_valid;
    logic [7:0]              r_tx_data;
    logic                    w_found;
    logic [GrantIdWidth-1:0] w_pick;
    logic                    w_can_load, w_accept, w_timeout;

    rr_pick #(
        .NumReq (NumReq),
        .IdWidth(GrantIdWidth)
    ) u_rr_pick (
        .Req  (ReqValid),
        .Ptr  (r_rr_ptr),
        .Found(w_found),
        .Index(w_pick)
    );

    // Loading only while the output register is empty and the transmitter idle
    // keeps TxData frozen for the whole serial frame.
    assign w_can_load  = (r_state == ST_LOCKED) && !r_tx_valid && TxReady;
    assign w_accept    = w_can_load && ReqValid[r_owner];
    assign w_owner_inc = (r_owner == GrantIdWidth'(NumReq - 1)) ? '0 : r_owner + GrantIdWidth'(1);

    always_comb begin
        w_idle_cnt_next = r_idle_cnt;
        w_timeout       = 1'b0;
        if (r_state != ST_LOCKED || w_accept) begin
            w_idle_cnt_next = '0;
        end else if (r_idle_cnt != {CountWidth{1'b1}}) begin
            w_idle_cnt_next = r_idle_cnt + CountWidth'(1);
        end
        if (IdleTimeout != 0 && r_state == ST_LOCKED && !w_accept &&
            w_idle_cnt_next == CountWidth'(IdleTimeout)) begin
            w_timeout       = 1'b1;
            w_idle_cnt_next = '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_ptr_next   = r_rr_ptr;
        ReqReady     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_next = ST_LOCKED;
                    w_owner_next = w_pick;
                end
            end
            ST_LOCKED: begin
                ReqReady[r_owner] = w_can_load;
                if ((w_accept && ReqLast[r_owner]) || w_timeout) begin
                    w_state_next = ST_IDLE;
                    w_ptr_next   = w_owner_inc;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_idle_cnt <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_state    <= w_state_next;
            r_rr_ptr   <= w_ptr_next;
            r_owner    <= w_owner_next;
            r_idle_cnt <= w_idle_cnt_next;
            if (w_accept) begin
                r_tx_valid <= 1'b1;
                r_tx_data  <= ReqData[8*r_owner +: 8];
            end else if (r_tx_valid && TxReady) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    assign TxData     = r_tx_data;
    assign TxValid    = r_tx_valid;
    assign GrantValid = (r_state == ST_LOCKED);
    assign GrantId    = r_owner;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed checks of uart_tx_arbiter against a message-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int NR = 3;

    logic            Clock = 1'b0;
    logic            Reset_n;
    logic [8*NR-1:0] ReqData;
    logic [NR-1:0]   ReqValid, ReqLast, ReqReady;
    logic [7:0]      TxData;
    logic            TxValid, TxReady, GrantValid;
    logic [1:0]      GrantId;

    logic [15:0]     b_ReqData;
    logic [1:0]      b_ReqValid, b_ReqLast, b_ReqReady;
    logic [7:0]      b_TxData;
    logic            b_TxValid, b_TxReady, b_GrantValid;
    logic [0:0]      b_GrantId;

    always #5 Clock = ~Clock;

    uart_tx_arbiter #(.NumReq(NR), .IdleTimeout(16)) dut_a (
        .Clock(Clock), .Reset_n(Reset_n), .ReqData(ReqData), .ReqValid(ReqValid),
        .ReqLast(ReqLast), .ReqReady(ReqReady), .TxData(TxData), .TxValid(TxValid),
        .TxReady(TxReady), .GrantValid(GrantValid), .GrantId(GrantId)
    );

    uart_tx_arbiter #(.NumReq(2), .IdleTimeout(0)) dut_b (
        .Clock(Clock), .Reset_n(Reset_n), .ReqData(b_ReqData), .ReqValid(b_ReqValid),
        .ReqLast(b_ReqLast), .ReqReady(b_ReqReady), .TxData(b_TxData), .TxValid(b_TxValid),
        .TxReady(b_TxReady), .GrantValid(b_GrantValid), .GrantId(b_GrantId)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0]  rq [NR][$];   // pending {last, data} per requester
    logic [10:0] acc_q[$];     // accepted {id, last, data}
    logic [7:0]  ser_q[$];     // bytes handed to the transmitter
    logic [10:0] exp_q[$];     // model expectation {id, last, data}
    int          gap [NR];
    bit          hs_req [NR];
    bit          hs_tx;
    logic [7:0]  tx_byte, frame_byte;
    int          busy;
    int          frame_min = 2, frame_max = 6;
    bit          rand_gaps = 0, tx_en = 1, toggle0 = 0;
    logic [7:0]  tog = 8'h55;
    int          m_ptr = 0;

    task automatic clear_bench();
        for (int i = 0; i < NR; i++) begin
            rq[i].delete();
            gap[i] = 0;
            hs_req[i] = 0;
        end
        hs_tx = 0; busy = 0;
        acc_q.delete(); ser_q.delete(); exp_q.delete();
        ReqValid = '0; ReqData = '0; ReqLast = '0;
        TxReady = 1'b1; tx_en = 1; toggle0 = 0; rand_gaps = 0;
        m_ptr = 0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        clear_bench();
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
    endtask

    // One clock: apply last edge's handshakes to the requester/transmitter models,
    // drive new inputs mid-cycle, then sample what the coming edge will do.
    task automatic run_cycle();
        @(negedge Clock);
        for (int i = 0; i < NR; i++) begin
            if (hs_req[i] && rq[i].size() > 0) begin
                acc_q.push_back({2'(i), rq[i][0]});
                if (!rq[i][0][8] && rand_gaps) gap[i] = $urandom_range(0, 2);
                void'(rq[i].pop_front());
            end else if (gap[i] > 0) begin
                gap[i]--;
            end
        end
        if (hs_tx) begin
            ser_q.push_back(tx_byte);
            frame_byte = tx_byte;
            busy = $urandom_range(frame_min, frame_max);
        end else if (busy > 0) begin
            busy--;
        end
        for (int i = 0; i < NR; i++) begin
            ReqValid[i] = (rq[i].size() > 0) && (gap[i] == 0);
            if (ReqValid[i]) begin
                ReqData[8*i +: 8] = rq[i][0][7:0];
                ReqLast[i]        = rq[i][0][8];
            end else begin
                ReqData[8*i +: 8] = 8'($urandom);
                ReqLast[i]        = 1'($urandom);
            end
        end
        if (toggle0) begin
            ReqData[7:0] = tog;
            tog = ~tog;
        end
        TxReady = tx_en && (busy == 0);
        #1;
        for (int i = 0; i < NR; i++) hs_req[i] = ReqValid[i] && ReqReady[i];
        hs_tx   = TxValid && TxReady;
        tx_byte = TxData;
    endtask

    function automatic bit quiet();
        bit q;
        q = !hs_tx && (busy == 0) && (TxValid !== 1'b1) && (GrantValid !== 1'b1);
        for (int i = 0; i < NR; i++) if (rq[i].size() != 0 || hs_req[i]) q = 0;
        return q;
    endfunction

    task automatic drain(output bit ok);
        int c = 0;
        while (!quiet() && c < 3000) begin
            run_cycle();
            c++;
        end
        ok = quiet();
    endtask

    // Message-level round robin: whole messages, first requester with work at or after the pointer.
    task automatic expect_rr();
        logic [8:0] cp [NR][$];
        bit         any;
        for (int i = 0; i < NR; i++) cp[i] = rq[i];
        any = 1;
        while (any) begin
            any = 0;
            for (int k = 0; k < NR && !any; k++) begin
                int i;
                i = (m_ptr + k) % NR;
                if (cp[i].size() > 0) begin
                    bit last;
                    any  = 1;
                    last = 0;
                    while (!last && cp[i].size() > 0) begin
                        exp_q.push_back({2'(i), cp[i][0]});
                        last = cp[i][0][8];
                        void'(cp[i].pop_front());
                    end
                    m_ptr = (i + 1) % NR;
                end
            end
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        clear_bench();
        b_ReqValid = '0; b_ReqData = '0; b_ReqLast = '0; b_TxReady = 1'b1;
        #3;
        n_cmp++;
        if ({TxValid, TxData, ReqReady, GrantValid, GrantId} !== '0)
            $display("FAIL reset_a: got tv=%b td=%h rr=%b gv=%b gid=%0d, want all 0",
                     TxValid, TxData, ReqReady, GrantValid, GrantId);
        n_cmp++;
        if ({b_TxValid, b_TxData, b_ReqReady, b_GrantValid, b_GrantId} !== '0)
            $display("FAIL reset_b: got tv=%b td=%h rr=%b gv=%b, want all 0",
                     b_TxValid, b_TxData, b_ReqReady, b_GrantValid);
        if ({TxValid, TxData, ReqReady, GrantValid, GrantId} !== '0) n_bad++;
        if ({b_TxValid, b_TxData, b_ReqReady, b_GrantValid, b_GrantId} !== '0) n_bad++;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (3) run_cycle();
        n_cmp++;
        if (GrantValid !== 1'b0 || TxValid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got gv=%b tv=%b, want 0 0", GrantValid, TxValid);
        end
    endtask

    task automatic test_single_message();
        bit ok;
        do_reset();
        frame_min = 8; frame_max = 8;
        rq[0].push_back({1'b0, 8'h48});
        rq[0].push_back({1'b1, 8'h69});
        expect_rr();
        run_cycle();
        n_cmp++;
        if (GrantValid !== 1'b0) begin
            n_bad++; $display("FAIL single_c0_grant: got %b want 0", GrantValid);
        end
        run_cycle();
        n_cmp++;
        if (GrantValid !== 1'b1 || GrantId !== 2'd0 || ReqReady !== 3'b001) begin
            n_bad++;
            $display("FAIL single_c1: got gv=%b gid=%0d rr=%b want 1 0 001", GrantValid, GrantId, ReqReady);
        end
        run_cycle();
        n_cmp++;
        if (TxValid !== 1'b1 || TxData !== 8'h48) begin
            n_bad++; $display("FAIL single_c2: got tv=%b td=%h want 1 48", TxValid, TxData);
        end
        run_cycle();
        n_cmp++;
        if (TxValid !== 1'b0) begin
            n_bad++; $display("FAIL single_c3_tv: got %b want 0", TxValid);
        end
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (TxData !== 8'h48) begin
                n_bad++; $display("FAIL single_frame_hold: cycle %0d got %h want 48", k, TxData);
            end
            run_cycle();
        end
        drain(ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL single_drain: got busy, want quiet"); end
        n_cmp++;
        if (ser_q.size() != 2) begin
            n_bad++; $display("FAIL single_count: got %0d bytes want 2", ser_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < ser_q.size(); k++) begin
            n_cmp++;
            if (ser_q[k] !== exp_q[k][7:0]) begin
                n_bad++; $display("FAIL single_byte%0d: got %h want %h", k, ser_q[k], exp_q[k][7:0]);
            end
        end
        frame_min = 2; frame_max = 6;
    endtask

    task automatic test_contention();
        bit ok;
        do_reset();
        rq[0].push_back({1'b0, 8'hA0}); rq[0].push_back({1'b0, 8'hA1}); rq[0].push_back({1'b1, 8'hA2});
        rq[1].push_back({1'b0, 8'hB0}); rq[1].push_back({1'b1, 8'hB1});
        expect_rr();
        drain(ok);
        rq[0].push_back({1'b1, 8'hC0});
        rq[1].push_back({1'b1, 8'hD0});
        expect_rr();
        drain(ok);
        n_cmp++;
        if (!ok || acc_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL contention_len: got %0d accepts (quiet=%b) want %0d", acc_q.size(), ok, exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
            n_cmp++;
            if (acc_q[k] !== exp_q[k] || ser_q[k] !== exp_q[k][7:0]) begin
                n_bad++;
                $display("FAIL contention_order%0d: got id/byte %h ser %h want %h", k, acc_q[k], ser_q[k], exp_q[k]);
            end
        end
    endtask

    task automatic test_data_stability();
        do_reset();
        tx_en = 0; toggle0 = 1;
        rq[0].push_back({1'b0, 8'hAA});
        for (int k = 0; k < 12; k++) begin
            run_cycle();
            n_cmp++;
            if (TxData !== 8'h00 || ReqReady[0] !== 1'b0 || TxValid !== 1'b0) begin
                n_bad++;
                $display("FAIL stability%0d: got td=%h rr0=%b tv=%b want 00 0 0", k, TxData, ReqReady[0], TxValid);
            end
        end
    endtask

    task automatic test_timeout();
        int guard = 0;
        int n_hold = 0;
        bit ok;
        do_reset();
        rq[1].push_back({1'b0, 8'h11});
        while (!hs_req[1] && guard < 20) begin run_cycle(); guard++; end
        n_cmp++;
        if (!hs_req[1]) begin n_bad++; $display("FAIL timeout_accept: got none want req1 accept"); end
        rq[0].push_back({1'b1, 8'h22});
        guard = 0;
        run_cycle();
        while (GrantValid === 1'b1 && GrantId === 2'd1 && guard < 100) begin
            n_hold++; run_cycle(); guard++;
        end
        n_cmp++;
        if (n_hold != 16 || GrantValid !== 1'b0) begin
            n_bad++; $display("FAIL timeout_hold: got %0d stall cycles gv=%b want 16 0", n_hold, GrantValid);
        end
        run_cycle();
        n_cmp++;
        if (GrantValid !== 1'b1 || GrantId !== 2'd0) begin
            n_bad++; $display("FAIL timeout_regrant: got gv=%b gid=%0d want 1 0", GrantValid, GrantId);
        end
        drain(ok);
        n_cmp++;
        if (!ok || ser_q.size() != 2 || ser_q[0] !== 8'h11 || ser_q[1] !== 8'h22) begin
            n_bad++; $display("FAIL timeout_bytes: got %0d bytes quiet=%b want 11 22", ser_q.size(), ok);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int guard = 0;
        do_reset();
        rq[0].push_back({1'b1, 8'h5A});
        drain(ok);
        rq[2].push_back({1'b0, 8'hC3});
        rq[2].push_back({1'b1, 8'h3C});
        while (TxValid !== 1'b1 && guard < 20) begin run_cycle(); guard++; end
        n_cmp++;
        if (TxValid !== 1'b1 || TxData !== 8'hC3) begin
            n_bad++; $display("FAIL rstmid_pre: got tv=%b td=%h want 1 c3", TxValid, TxData);
        end
        #1 Reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({TxValid, TxData, ReqReady, GrantValid, GrantId} !== '0) begin
            n_bad++;
            $display("FAIL rstmid_async: got tv=%b td=%h rr=%b gv=%b gid=%0d want all 0",
                     TxValid, TxData, ReqReady, GrantValid, GrantId);
        end
        clear_bench();
        @(negedge Clock);
        Reset_n = 1'b1;
        rq[0].push_back({1'b1, 8'h01});
        rq[2].push_back({1'b1, 8'h02});
        expect_rr();
        drain(ok);
        n_cmp++;
        if (!ok || acc_q.size() != 2 || acc_q[0] !== exp_q[0] || acc_q[1] !== exp_q[1]) begin
            n_bad++;
            $display("FAIL rstmid_restart: got %0d accepts first=%h want %h then %h",
                     acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 11'h7ff, exp_q[0], exp_q[1]);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            int c = 0;
            if (r == 0) do_reset();
            acc_q.delete(); ser_q.delete(); exp_q.delete();
            rand_gaps = 1;
            for (int i = 0; i < NR; i++) begin
                int nm;
                nm = $urandom_range(1, 3);
                for (int m = 0; m < nm; m++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) rq[i].push_back({b == len - 1, 8'($urandom)});
                end
            end
            expect_rr();
            while (!quiet() && c < 3000) begin
                run_cycle();
                c++;
                if (busy > 0) begin
                    n_cmp++;
                    if (TxData !== frame_byte) begin
                        n_bad++; $display("FAIL rand_frame_hold: got %h want %h", TxData, frame_byte);
                    end
                end
                n_cmp++;
                if (!$onehot0(ReqReady)) begin
                    n_bad++; $display("FAIL rand_ready_onehot: got %b want at most one bit", ReqReady);
                end
            end
            n_cmp++;
            if (!quiet() || acc_q.size() != exp_q.size() || ser_q.size() != exp_q.size()) begin
                n_bad++;
                $display("FAIL rand_len round %0d: got acc=%0d ser=%0d want %0d", r, acc_q.size(), ser_q.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < acc_q.size() && k < ser_q.size(); k++) begin
                n_cmp++;
                if (acc_q[k] !== exp_q[k] || ser_q[k] !== exp_q[k][7:0]) begin
                    n_bad++;
                    $display("FAIL rand_seq r%0d k%0d: got %h ser %h want %h", r, k, acc_q[k], ser_q[k], exp_q[k]);
                end
            end
        end
        rand_gaps = 0;
    endtask

    task automatic test_timeout_disabled();
        int bad_cyc = 0;
        int guard = 0;
        @(negedge Clock);
        b_TxReady = 1'b1; b_ReqValid = 2'b01; b_ReqData = 16'h0077; b_ReqLast = 2'b00;
        @(negedge Clock); #1;
        n_cmp++;
        if (b_GrantValid !== 1'b1 || b_GrantId !== 1'b0 || b_ReqReady !== 2'b01) begin
            n_bad++;
            $display("FAIL notimeout_grant: got gv=%b gid=%0d rr=%b want 1 0 01", b_GrantValid, b_GrantId, b_ReqReady);
        end
        @(negedge Clock);
        b_ReqValid = 2'b10; b_ReqData = 16'h5500;
        for (int k = 0; k < 10000; k++) begin
            @(negedge Clock); #1;
            if (b_GrantValid !== 1'b1 || b_GrantId !== 1'b0 || b_ReqReady[1] !== 1'b0) bad_cyc++;
        end
        n_cmp++;
        if (bad_cyc != 0) begin
            n_bad++; $display("FAIL notimeout_hold: got %0d bad cycles want 0", bad_cyc);
        end
        @(negedge Clock);
        b_ReqValid = 2'b11; b_ReqLast = 2'b01; b_ReqData = 16'h5588;
        @(negedge Clock);
        b_ReqValid = 2'b10;
        while (!(b_GrantValid === 1'b1 && b_GrantId === 1'b1) && guard < 20) begin
            @(negedge Clock); #1; guard++;
        end
        n_cmp++;
        if (b_GrantValid !== 1'b1 || b_GrantId !== 1'b1) begin
            n_bad++; $display("FAIL notimeout_release: got gv=%b gid=%0d want 1 1", b_GrantValid, b_GrantId);
        end
        b_ReqValid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single_message();
        test_contention();
        test_data_stability();
        test_timeout();
        test_reset_mid();
        test_random();
        test_timeout_disabled();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
